// File: rtl/dout_signature_capture.sv
// dout_signature_capture
// Compresses a window of valid upstream dout words into a Galois-form MISR
// signature. When the window is full the block compares the signature with a
// golden value and holds the result until sig_ack.
module dout_signature_capture #(
    parameter int              DW      = 32,
    parameter int              WIN_LEN = 256,
    parameter logic [DW-1:0]   POLY    = 32'h04C11DB7,
    parameter logic [DW-1:0]   SEED    = 32'hFFFFFFFF,
    localparam int             CW      = $clog2(WIN_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    input  logic [DW-1:0] golden,
    output logic          busy,
    output logic          sig_valid,
    input  logic          sig_ack,
    output logic [DW-1:0] signature,
    output logic          match,
    output logic [CW-1:0] sample_cnt
);

    // One-hot encoding lets busy and sig_valid come straight off state flops.
    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        CAPTURE = 3'b010,
        DONE    = 3'b100
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(WIN_LEN - 1);

    state_t        state_q, state_d;
    logic [DW-1:0] sig_q, sig_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          match_q, match_d;
    logic [DW-1:0] sig_fold;
    logic          last_sample;

    // One MISR step: shift left, apply feedback on the MSB, fold in the data.
    function automatic logic [DW-1:0] misr_step(input logic [DW-1:0] s,
                                                input logic [DW-1:0] d);
        return {s[DW-2:0], 1'b0} ^ (s[DW-1] ? POLY : '0) ^ d;
    endfunction

    // Folded value and end-of-window detect for the current sample.
    always_comb begin
        sig_fold    = misr_step(sig_q, din);
        last_sample = din_valid && (cnt_q == LAST_CNT);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start outside IDLE is dropped, ack wins over start in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)       state_d = CAPTURE;
            CAPTURE: if (last_sample) state_d = DONE;
            DONE:    if (sig_ack)     state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Status outputs decoded directly from the one-hot state flops.
    always_comb begin
        busy      = state_q[1];
        sig_valid = state_q[2];
    end

    // Datapath next values: seed on start, fold on valid samples, compare on DONE entry.
    always_comb begin
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        match_d = match_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sig_d   = SEED;
                    cnt_d   = '0;
                    match_d = 1'b0;
                end
            end
            CAPTURE: begin
                if (din_valid) begin
                    sig_d = sig_fold;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        match_d = (sig_fold == golden);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; reset discards any partial signature.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_q   <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
        end else begin
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
        end
    end

    // Result outputs are the registers themselves.
    always_comb begin
        signature  = sig_q;
        sample_cnt = cnt_q;
        match      = match_q;
    end

endmodule

// File: tb/tb_dout_signature_capture.sv
// Scoreboard bench for dout_signature_capture: four instances cover window
// lengths 1, 2, 4 and 256; expected results are queued at stimulus time and
// popped by per-instance monitors when sig_valid rises.
module tb_dout_signature_capture;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    typedef struct packed {
        logic [31:0] sig;
        logic [31:0] cnt;
        logic        m;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_s [4];
    logic [31:0] din_s   [4];
    logic        dv_s    [4];
    logic [31:0] golden_s[4];
    logic        ack_s   [4];
    logic        busy_s  [4];
    logic        sv_s    [4];
    logic [31:0] sig_s   [4];
    logic        mt_s    [4];
    logic        sv_prev [4];
    logic [0:0]  cnt0;
    logic [1:0]  cnt1;
    logic [2:0]  cnt2;
    logic [8:0]  cnt3;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dout_signature_capture #(.WIN_LEN(1)) u0 (
        .clk(clk), .reset(reset), .start(start_s[0]), .din(din_s[0]),
        .din_valid(dv_s[0]), .golden(golden_s[0]), .busy(busy_s[0]),
        .sig_valid(sv_s[0]), .sig_ack(ack_s[0]), .signature(sig_s[0]),
        .match(mt_s[0]), .sample_cnt(cnt0));

    dout_signature_capture #(.WIN_LEN(2), .SEED(32'h0)) u1 (
        .clk(clk), .reset(reset), .start(start_s[1]), .din(din_s[1]),
        .din_valid(dv_s[1]), .golden(golden_s[1]), .busy(busy_s[1]),
        .sig_valid(sv_s[1]), .sig_ack(ack_s[1]), .signature(sig_s[1]),
        .match(mt_s[1]), .sample_cnt(cnt1));

    dout_signature_capture #(.WIN_LEN(4)) u2 (
        .clk(clk), .reset(reset), .start(start_s[2]), .din(din_s[2]),
        .din_valid(dv_s[2]), .golden(golden_s[2]), .busy(busy_s[2]),
        .sig_valid(sv_s[2]), .sig_ack(ack_s[2]), .signature(sig_s[2]),
        .match(mt_s[2]), .sample_cnt(cnt2));

    dout_signature_capture u3 (
        .clk(clk), .reset(reset), .start(start_s[3]), .din(din_s[3]),
        .din_valid(dv_s[3]), .golden(golden_s[3]), .busy(busy_s[3]),
        .sig_valid(sv_s[3]), .sig_ack(ack_s[3]), .signature(sig_s[3]),
        .match(mt_s[3]), .sample_cnt(cnt3));

    function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [31:0] d);
        logic [31:0] t;
        t = s << 1;
        if (s[31]) t = t ^ POLY;
        return t ^ d;
    endfunction

    function automatic logic [31:0] word3(input int i);
        return 32'(i) * 32'h9E3779B9 + 32'h12345678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int k);
        start_s[k] = 1'b1;
        tick();
        start_s[k] = 1'b0;
    endtask

    task automatic feed(input int k, input logic [31:0] w);
        din_s[k] = w;
        dv_s[k]  = 1'b1;
        tick();
        dv_s[k]  = 1'b0;
    endtask

    task automatic do_ack(input int k);
        ack_s[k] = 1'b1;
        tick();
        ack_s[k] = 1'b0;
    endtask

    // Monitors: pop one expected result per rising sig_valid.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (sv_s[0] && !sv_prev[0]) begin
            if (q0.size() == 0) chk("u0_unexpected_valid", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                chk("u0_signature", sig_s[0], e.sig);
                chk("u0_sample_cnt", 32'(cnt0), e.cnt);
                chk("u0_match", 32'(mt_s[0]), 32'(e.m));
            end
        end
        sv_prev[0] = sv_s[0];
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (sv_s[1] && !sv_prev[1]) begin
            if (q1.size() == 0) chk("u1_unexpected_valid", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                chk("u1_signature", sig_s[1], e.sig);
                chk("u1_sample_cnt", 32'(cnt1), e.cnt);
                chk("u1_match", 32'(mt_s[1]), 32'(e.m));
            end
        end
        sv_prev[1] = sv_s[1];
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (sv_s[2] && !sv_prev[2]) begin
            if (q2.size() == 0) chk("u2_unexpected_valid", 32'd1, 32'd0);
            else begin
                e = q2.pop_front();
                chk("u2_signature", sig_s[2], e.sig);
                chk("u2_sample_cnt", 32'(cnt2), e.cnt);
                chk("u2_match", 32'(mt_s[2]), 32'(e.m));
            end
        end
        sv_prev[2] = sv_s[2];
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (sv_s[3] && !sv_prev[3]) begin
            if (q3.size() == 0) chk("u3_unexpected_valid", 32'd1, 32'd0);
            else begin
                e = q3.pop_front();
                chk("u3_signature", sig_s[3], e.sig);
                chk("u3_sample_cnt", 32'(cnt3), e.cnt);
                chk("u3_match", 32'(mt_s[3]), 32'(e.m));
            end
        end
        sv_prev[3] = sv_s[3];
    end

    initial begin : stim
        logic [31:0] w2 [4];
        logic        pat[7];
        logic [31:0] exp2;
        logic [31:0] exp3;
        int          widx;

        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            start_s[k] = 1'b0; din_s[k] = '0; dv_s[k] = 1'b0;
            golden_s[k] = '0;  ack_s[k] = 1'b0; sv_prev[k] = 1'b0;
        end

        // Reset state
        #2;
        chk("rst_busy", 32'(busy_s[3]), 32'd0);
        chk("rst_sig_valid", 32'(sv_s[3]), 32'd0);
        chk("rst_match", 32'(mt_s[3]), 32'd0);
        chk("rst_signature", sig_s[0], 32'd0);
        chk("rst_sample_cnt", 32'(cnt3), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Seed fold with zero data, window of one
        golden_s[0] = 32'hFB3EE249;
        q0.push_back('{32'hFB3EE249, 32'd1, 1'b1});
        do_start(0);
        chk("u0_busy_after_start", 32'(busy_s[0]), 32'd1);
        chk("u0_no_valid_yet", 32'(sv_s[0]), 32'd0);
        feed(0, 32'h0);
        chk("u0_valid_after_fold", 32'(sv_s[0]), 32'd1);
        chk("u0_busy_low_in_done", 32'(busy_s[0]), 32'd0);
        do_ack(0);
        chk("u0_valid_cleared", 32'(sv_s[0]), 32'd0);

        // Simple accumulate, zero seed, golden match then mismatch
        for (int r = 0; r < 2; r++) begin
            golden_s[1] = (r == 0) ? 32'd3 : 32'd4;
            q1.push_back('{32'd3, 32'd2, (r == 0)});
            do_start(1);
            feed(1, 32'd1);
            chk("u1_not_done_after_one", 32'(sv_s[1]), 32'd0);
            feed(1, 32'd1);
            chk("u1_done_after_two", 32'(sv_s[1]), 32'd1);
            do_ack(1);
        end

        // Gap-free window of four on u2, against the reference fold
        w2[0] = 32'h11111111; w2[1] = 32'h22222222;
        w2[2] = 32'h80000001; w2[3] = 32'h44444444;
        exp2 = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) exp2 = ref_step(exp2, w2[i]);
        golden_s[2] = exp2;
        q2.push_back('{exp2, 32'd4, 1'b1});
        do_start(2);
        for (int i = 0; i < 4; i++) feed(2, w2[i]);
        chk("u2_gapfree_done", 32'(sv_s[2]), 32'd1);
        do_ack(2);

        // Same words with valid gaps; junk on invalid cycles, start pulse mid-capture
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        pat[4] = 1'b1; pat[5] = 1'b0; pat[6] = 1'b1;
        golden_s[2] = exp2 ^ 32'h1;
        q2.push_back('{exp2, 32'd4, 1'b0});
        do_start(2);
        widx = 0;
        for (int i = 0; i < 7; i++) begin
            dv_s[2]    = pat[i];
            din_s[2]   = pat[i] ? w2[widx] : 32'hDEADBEEF;
            start_s[2] = (i == 2);
            if (pat[i]) widx++;
            tick();
            if (i == 2) chk("u2_gap_cnt_after_3", 32'(cnt2), 32'd1);
            if (i == 5) chk("u2_gap_not_done_early", 32'(sv_s[2]), 32'd0);
        end
        dv_s[2] = 1'b0;
        start_s[2] = 1'b0;
        chk("u2_gap_done_after_7", 32'(sv_s[2]), 32'd1);

        // Hold in DONE for ten cycles with a stray start
        for (int c = 0; c < 10; c++) begin
            start_s[2] = (c == 4);
            tick();
            chk("u2_hold_valid", 32'(sv_s[2]), 32'd1);
            chk("u2_hold_signature", sig_s[2], exp2);
            chk("u2_hold_busy", 32'(busy_s[2]), 32'd0);
        end
        start_s[2] = 1'b0;

        // start together with ack: ack wins, no new capture
        start_s[2] = 1'b1;
        ack_s[2]   = 1'b1;
        tick();
        start_s[2] = 1'b0;
        ack_s[2]   = 1'b0;
        chk("u2_startack_valid", 32'(sv_s[2]), 32'd0);
        chk("u2_startack_busy", 32'(busy_s[2]), 32'd0);
        tick();
        chk("u2_startack_still_idle", 32'(busy_s[2]), 32'd0);
        chk("u2_sig_kept_in_idle", sig_s[2], exp2);

        // Reset in the middle of a 256-sample window
        exp3 = 32'hFFFFFFFF;
        for (int i = 0; i < 256; i++) exp3 = ref_step(exp3, word3(i));
        golden_s[3] = exp3;
        do_start(3);
        for (int i = 0; i < 100; i++) feed(3, word3(i));
        chk("u3_cnt_before_reset", 32'(cnt3), 32'd100);
        chk("u3_busy_before_reset", 32'(busy_s[3]), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("u3_async_rst_busy", 32'(busy_s[3]), 32'd0);
        chk("u3_async_rst_signature", sig_s[3], 32'd0);
        chk("u3_async_rst_cnt", 32'(cnt3), 32'd0);
        chk("u3_async_rst_valid", 32'(sv_s[3]), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Two back-to-back full windows on identical data
        q3.push_back('{exp3, 32'd256, 1'b1});
        do_start(3);
        for (int i = 0; i < 256; i++) feed(3, word3(i));
        chk("u3_run1_done", 32'(sv_s[3]), 32'd1);
        do_ack(3);
        chk("u3_run1_acked", 32'(sv_s[3]), 32'd0);
        q3.push_back('{exp3, 32'd256, 1'b1});
        do_start(3);
        chk("u3_run2_busy", 32'(busy_s[3]), 32'd1);
        for (int i = 0; i < 256; i++) feed(3, word3(i));
        chk("u3_run2_done", 32'(sv_s[3]), 32'd1);
        do_ack(3);

        tick();
        tick();
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        chk("q3_drained", 32'(q3.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
